// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end. Issues one fetch per cycle while
// the FIFO plus the outstanding fetch leave room, buffers {pc, instr} pairs,
// and presents the head (or a NOP when empty) to IR1. A redirect flushes
// everything and restarts fetch at the branch target.
module fetch_queue #(
    parameter int         DEPTH     = 4,
    parameter logic [7:0] NOP_INSTR = 8'h0A
) (
    input  logic       clock,
    input  logic       reset,
    output logic [7:0] mem_addr,
    output logic       mem_rd,
    input  logic [7:0] mem_q,
    input  logic       stall,
    input  logic       redirect,
    input  logic [7:0] redirect_pc,
    output logic [7:0] ir_out,
    output logic [7:0] pc_out,
    output logic       ir_valid,
    output logic [2:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    r_fetch_pc;
    logic          r_inflight;
    logic [7:0]    r_inflight_pc;
    logic [7:0]    r_fifo_pc    [DEPTH];
    logic [7:0]    r_fifo_instr [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    // One bit wider than the output so DEPTH=8 is representable internally.
    logic [3:0]    r_count;

    logic [4:0]    w_occ;
    logic          w_issue;
    logic          w_enq;
    logic          w_deq;
    logic          w_valid;

    // Issue/enqueue/dequeue decisions; redirect overrides all of them.
    always_comb begin
        w_occ    = {1'b0, r_count} + {4'b0, r_inflight};
        w_issue  = !reset && !redirect && (w_occ < 5'(DEPTH));
        w_enq    = r_inflight && !redirect;
        w_valid  = (r_count != 4'd0);
        w_deq    = w_valid && !stall && !redirect;
    end

    // Head presentation: NOP/PC 0 whenever the FIFO is empty.
    always_comb begin
        mem_addr = r_fetch_pc;
        mem_rd   = w_issue;
        ir_valid = w_valid;
        ir_out   = w_valid ? r_fifo_instr[r_rd_ptr] : NOP_INSTR;
        pc_out   = w_valid ? r_fifo_pc[r_rd_ptr]    : 8'h00;
        count    = r_count[2:0];
    end

    // Fetch PC, in-flight tracking, pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_pc    <= 8'h00;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 8'h00;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= 4'd0;
        end else if (redirect) begin
            // The response landing this cycle belongs to the old path: drop it.
            r_fetch_pc <= redirect_pc;
            r_inflight <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= 4'd0;
        end else begin
            if (w_issue) begin
                r_inflight    <= 1'b1;
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + 8'd1;
            end else begin
                r_inflight <= 1'b0;
            end
            if (w_enq)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_deq)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents need no reset since the count gates visibility.
    always_ff @(posedge clock) begin
        if (!reset && w_enq) begin
            r_fifo_pc[r_wr_ptr]    <= r_inflight_pc;
            r_fifo_instr[r_wr_ptr] <= mem_q;
        end
    end

    // The issue throttle must make an enqueue into a full FIFO impossible.
    always_ff @(posedge clock) begin
        if (!reset && w_enq)
            assert (r_count < 4'(DEPTH));
    end

endmodule
